tri_bus_reader: RTL and testbench
=================================

# tri_bus_reader

Owner/reader side of the shared 4-bit tri-state data bus. It decides which tri-state source drives the bus by asserting exactly one source `enable` at a time. It waits a programmable settle time, samples the resolved bus, and returns the bus to high-Z for one turnaround cycle. Captured nibbles, tagged with their source ID, go to downstream logic over a valid/ready interface. Sources are serviced round-robin.

## Interface
- `NSRC`, default 4: number of tri-state sources on the bus.
- `WIDTH`, default 4: bus width in bits.
- `SETTLE`, default 1: number of DRIVE cycles before the sample cycle; legal range 1..15.
- `clk`  in  1: single clock; all state changes on the rising edge.
- `reset`  in  1: synchronous, active-high reset.
- `req`  in  NSRC: per-source request; bit k means source k has data to place on the bus.
- `bus_in`  in  WIDTH: resolved value of the shared tri-state bus.
- `enable`  out  NSRC: one-hot-or-zero drive enable, one bit per source's tri-state buffer.
- `out_data`  out  WIDTH: captured bus value.
- `out_src`  out  clog2(NSRC): index of the source that produced `out_data`.
- `out_valid`  out  1: `out_data`/`out_src` hold an unconsumed item.
- `out_ready`  in  1: downstream accepts the item when `out_valid && out_ready`.
- `busy`  out  1: high whenever the FSM is not in IDLE.

## Operation
- FSM states: IDLE, DRIVE, SAMPLE, TURN.
- IDLE: a grant starts when `req != 0` and (`!out_valid || out_ready`).
  - The chosen source k is the first set bit of `req`, searching from pointer `ptr` upward with wrap modulo NSRC.
  - On a grant, the next state is DRIVE, `enable <= onehot(k)`, the settle counter is cleared, and `ptr <= (k+1) mod NSRC`.
  - With no grant, the FSM stays in IDLE and `enable` stays 0.
- DRIVE: `enable` is held; the counter increments; the FSM moves to SAMPLE after SETTLE cycles in DRIVE.
- SAMPLE: `enable` is still held. At the end of this cycle `out_data <= bus_in`, `out_src <= k`, `out_valid <= 1`, and `enable <= 0`; the next state is TURN.
- TURN: one cycle with all enables 0 (bus turnaround); the next state is IDLE.
- Output register: `out_valid` clears on the cycle after `out_valid && out_ready`. Data is never overwritten while it is valid and unconsumed; the IDLE grant rule guarantees this.
- Requests are sampled only in IDLE.
  - A `req` bit dropping after grant is ignored: the transaction completes and the sample is delivered.
  - A `req` bit rising mid-transaction waits for the next IDLE.
- Invariants:
  - `enable` is one-hot or zero at all times.
  - `enable` is zero in IDLE and TURN.
  - `enable` never changes between the grant and the end of SAMPLE.
- Reset values: `enable=0`, `out_valid=0`, `out_data=0`, `out_src=0`, `busy=0`, `ptr=0`, state IDLE, counter 0.
- Reset asserted mid-transaction: all of the above take effect on the next edge, and any in-flight sample is discarded.

## Timing
- With grant decided in IDLE at cycle n:
  - `enable` is high on cycles n+1 .. n+SETTLE+1.
  - `bus_in` is sampled at the end of cycle n+SETTLE+1.
  - `out_valid` rises at cycle n+SETTLE+2, which is also the TURN cycle.
  - The FSM is back in IDLE at n+SETTLE+3.
- Back-to-back period is SETTLE+3 cycles (4 with the default).
- `busy` is high on cycles n+1 .. n+SETTLE+2.
- Backpressure: while `out_valid=1 && out_ready=0`, no grant occurs and `enable` stays 0. In the cycle `out_ready` rises, IDLE may grant, so `enable` rises one cycle later.
- `bus_in` is assumed stable by the sample edge, given SETTLE ≥ 1 cycle of drive.

## Test plan
- Reset: hold `reset=1` 3 cycles with `req=4'b1111` → `enable=0000`, `out_valid=0`, `out_data=0000`, `busy=0` throughout.
- Single read, default params: `req=4'b0100` in cycle n, bench drives `bus_in=4'b0110` only while `enable[2]=1` → `enable=0100` on n+1..n+2, `out_valid=1`, `out_data=0110`, `out_src=2` at n+3, `enable=0000` at n+3.
- Round-robin: `req=4'b1111` constant, `out_ready=1`, bus value = source index → `out_src` sequence 0,1,2,3,0 with `out_valid` pulses 4 cycles apart; `enable` never has two bits set.
- Backpressure: `req=4'b0011`, `out_ready=0` → first item (src 0) is held indefinitely with `enable=0000`. Raise `out_ready` for 1 cycle → next grant is src 1, and `out_data` for src 0 is unchanged until consumed.
- Reset mid-transaction: assert `reset` during DRIVE with `enable=0010` → `enable=0000` and state IDLE on the next edge, `out_valid` never rises, and the next grant after reset starts search at src 0.
- Parameter sweep, `SETTLE=3`: single request to src 3 → `enable=1000` for 4 cycles, `out_valid` at n+5, back-to-back period 6 cycles.

Source files
------------

// File: rtl/tri_bus_reader.sv
// Owner/reader side of a shared tri-state bus: grants one source at a time round-robin,
// waits SETTLE drive cycles, samples the bus, then leaves one idle turnaround cycle.
//
// state  | meaning
// IDLE   | no source enabled; grant when a request is pending and the output slot is free
// DRIVE  | chosen source drives the bus; settle counter runs for SETTLE cycles
// SAMPLE | source still enabled; bus captured into the output register at the end of this cycle
// TURN   | all enables low so the bus returns to high-Z before the next grant
module tri_bus_reader #(
    parameter int NSRC   = 4,
    parameter int WIDTH  = 4,
    parameter int SETTLE = 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NSRC-1:0]         req,
    input  logic [WIDTH-1:0]        bus_in,
    output logic [NSRC-1:0]         enable,
    output logic [WIDTH-1:0]        out_data,
    output logic [$clog2(NSRC)-1:0] out_src,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic                    busy
);
    localparam int SW = $clog2(NSRC);
    localparam int CW = 4;

    typedef enum logic [1:0] {IDLE, DRIVE, SAMPLE, TURN} state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [SW-1:0]    ptr_q, ptr_d;
    logic [SW-1:0]    src_q, src_d;
    logic [NSRC-1:0]  enable_q, enable_d;
    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic [SW-1:0]    out_src_q, out_src_d;
    logic             out_valid_q, out_valid_d;

    logic             grant_found;
    logic [SW-1:0]    grant_src;
    int               idx;

    // First requesting source at or above ptr, wrapping modulo NSRC.
    always_comb begin
        grant_found = 1'b0;
        grant_src   = '0;
        idx         = 0;
        for (int i = 0; i < NSRC; i++) begin
            idx = (int'(ptr_q) + i) % NSRC;
            if (!grant_found && req[idx]) begin
                grant_found = 1'b1;
                grant_src   = SW'(idx);
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        ptr_d       = ptr_q;
        src_d       = src_q;
        enable_d    = enable_q;
        out_data_d  = out_data_q;
        out_src_d   = out_src_q;
        out_valid_d = out_valid_q;

        if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                enable_d = '0;
                if (grant_found && (!out_valid_q || out_ready)) begin
                    state_d  = DRIVE;
                    cnt_d    = '0;
                    src_d    = grant_src;
                    enable_d = NSRC'(1) << grant_src;
                    ptr_d    = (grant_src == SW'(NSRC - 1)) ? '0 : grant_src + SW'(1);
                end
            end
            DRIVE: begin
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(SETTLE - 1)) begin
                    state_d = SAMPLE;
                end
            end
            SAMPLE: begin
                out_data_d  = bus_in;
                out_src_d   = src_q;
                out_valid_d = 1'b1;
                enable_d    = '0;
                state_d     = TURN;
            end
            TURN: begin
                enable_d = '0;
                state_d  = IDLE;
            end
            default: begin
                enable_d = '0;
                state_d  = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            ptr_q       <= '0;
            src_q       <= '0;
            enable_q    <= '0;
            out_data_q  <= '0;
            out_src_q   <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            ptr_q       <= ptr_d;
            src_q       <= src_d;
            enable_q    <= enable_d;
            out_data_q  <= out_data_d;
            out_src_q   <= out_src_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign enable    = enable_q;
    assign out_data  = out_data_q;
    assign out_src   = out_src_q;
    assign out_valid = out_valid_q;
    assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_tri_bus_reader.sv
// Directed bench for tri_bus_reader: default-parameter instance plus a SETTLE=3 instance,
// each with a wired-OR bus model fed by per-source values.
module tb_tri_bus_reader;
    logic       clk;
    logic       reset;

    logic [3:0] req_a, bus_a, en_a, data_a;
    logic [1:0] src_out_a;
    logic       valid_a, ready_a, busy_a;
    logic [3:0] src_a [4];

    logic [3:0] req_b, bus_b, en_b, data_b;
    logic [1:0] src_out_b;
    logic       valid_b, ready_b, busy_b;
    logic [3:0] src_b [4];

    int checks = 0;
    int errors = 0;
    int j, ph;
    logic [3:0] exp_en;

    tri_bus_reader dut (
        .clk(clk), .reset(reset), .req(req_a), .bus_in(bus_a), .enable(en_a),
        .out_data(data_a), .out_src(src_out_a), .out_valid(valid_a),
        .out_ready(ready_a), .busy(busy_a)
    );

    tri_bus_reader #(.SETTLE(3)) dut3 (
        .clk(clk), .reset(reset), .req(req_b), .bus_in(bus_b), .enable(en_b),
        .out_data(data_b), .out_src(src_out_b), .out_valid(valid_b),
        .out_ready(ready_b), .busy(busy_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        bus_a = '0;
        bus_b = '0;
        for (int k = 0; k < 4; k++) begin
            if (en_a[k]) bus_a = bus_a | src_a[k];
            if (en_b[k]) bus_b = bus_b | src_b[k];
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    initial begin
        for (int k = 0; k < 4; k++) begin
            src_a[k] = '0;
            src_b[k] = '0;
        end
        reset   = 1'b1;
        req_a   = 4'b1111;
        req_b   = 4'b1111;
        ready_a = 1'b1;
        ready_b = 1'b1;

        // reset held three cycles with every request active
        repeat (3) begin
            @(negedge clk);
            chk("rst_en", en_a, 4'b0000);
            chk("rst_valid", valid_a, 0);
            chk("rst_data", data_a, 4'b0000);
            chk("rst_busy", busy_a, 0);
        end
        reset = 1'b0;
        req_a = '0;
        req_b = '0;
        @(negedge clk);

        // single read from source 2; request dropped right after the grant
        src_a[2] = 4'b0110;
        req_a    = 4'b0100;
        @(negedge clk);
        req_a = '0;
        chk("sr_en1", en_a, 4'b0100);
        chk("sr_busy1", busy_a, 1);
        @(negedge clk);
        chk("sr_en2", en_a, 4'b0100);
        chk("sr_valid_early", valid_a, 0);
        @(negedge clk);
        chk("sr_en3", en_a, 4'b0000);
        chk("sr_valid", valid_a, 1);
        chk("sr_data", data_a, 4'b0110);
        chk("sr_src", src_out_a, 2);
        chk("sr_busy3", busy_a, 1);
        @(negedge clk);
        chk("sr_busy4", busy_a, 0);
        chk("sr_consumed", valid_a, 0);

        // round robin, all requesting, bus value equals source index
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        for (int k = 0; k < 4; k++) src_a[k] = 4'(k);
        req_a = 4'b1111;
        for (int cyc = 1; cyc <= 20; cyc++) begin
            @(negedge clk);
            j  = cyc / 4;
            ph = cyc % 4;
            exp_en = (ph == 1 || ph == 2) ? 4'(1 << (j % 4)) : 4'b0000;
            chk("rr_en", en_a, exp_en);
            chk("rr_valid", valid_a, (ph == 3) ? 1 : 0);
            if (ph == 3) begin
                chk("rr_src", src_out_a, j % 4);
                chk("rr_data", data_a, j % 4);
            end
            if (cyc == 20) req_a = '0;
        end
        @(negedge clk);

        // backpressure: src 0 held until out_ready pulses, then src 1 granted
        reset = 1'b1;
        @(negedge clk);
        reset    = 1'b0;
        src_a[0] = 4'b1010;
        src_a[1] = 4'b0101;
        req_a    = 4'b0011;
        ready_a  = 1'b0;
        @(negedge clk);
        chk("bp_en0", en_a, 4'b0001);
        @(negedge clk);
        @(negedge clk);
        chk("bp_valid0", valid_a, 1);
        chk("bp_data0", data_a, 4'b1010);
        chk("bp_src0", src_out_a, 0);
        repeat (6) begin
            @(negedge clk);
            chk("bp_hold_en", en_a, 4'b0000);
            chk("bp_hold_valid", valid_a, 1);
            chk("bp_hold_data", data_a, 4'b1010);
            chk("bp_hold_busy", busy_a, 0);
        end
        ready_a = 1'b1;
        @(negedge clk);
        ready_a = 1'b0;
        chk("bp_en1a", en_a, 4'b0010);
        chk("bp_popped", valid_a, 0);
        @(negedge clk);
        chk("bp_en1b", en_a, 4'b0010);
        @(negedge clk);
        chk("bp_valid1", valid_a, 1);
        chk("bp_data1", data_a, 4'b0101);
        chk("bp_src1", src_out_a, 1);
        chk("bp_en_turn", en_a, 4'b0000);
        req_a   = '0;
        ready_a = 1'b1;
        @(negedge clk);
        @(negedge clk);

        // reset during DRIVE discards the transaction and rewinds the pointer
        req_a = 4'b0010;
        @(negedge clk);
        chk("rm_en_drive", en_a, 4'b0010);
        reset = 1'b1;
        @(negedge clk);
        chk("rm_en", en_a, 4'b0000);
        chk("rm_busy", busy_a, 0);
        chk("rm_valid", valid_a, 0);
        reset = 1'b0;
        req_a = 4'b1111;
        @(negedge clk);
        chk("rm_regrant", en_a, 4'b0001);
        chk("rm_valid2", valid_a, 0);
        req_a = '0;
        repeat (4) @(negedge clk);

        // SETTLE=3: four enable cycles, valid at n+5, period 6
        src_b[3] = 4'b1001;
        req_b    = 4'b1000;
        for (int cyc = 1; cyc <= 18; cyc++) begin
            @(negedge clk);
            ph = cyc % 6;
            exp_en = (ph >= 1 && ph <= 4) ? 4'b1000 : 4'b0000;
            chk("s3_en", en_b, exp_en);
            chk("s3_valid", valid_b, (ph == 5) ? 1 : 0);
            chk("s3_busy", busy_b, (ph != 0) ? 1 : 0);
            if (ph == 5) begin
                chk("s3_data", data_b, 4'b1001);
                chk("s3_src", src_out_b, 3);
            end
            if (cyc == 18) req_b = '0;
        end
        @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
